// File: rtl/iob2axi_burst_sched.sv
// Burst scheduler: splits a (addr, beats, direction) transfer into AXI4 bursts
// that never cross a 4KB page or exceed 2^AXI_LEN_W beats, and sequences the
// read/write engines one burst at a time.
module iob2axi_burst_sched #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  parameter int unsigned TOTAL_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  direction,
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [TOTAL_W-1:0]    length,
  output logic                  ready,
  output logic                  error,
  output logic                  run_rd,
  output logic                  run_wr,
  output logic [AXI_ADDR_W-1:0] burst_addr,
  output logic [AXI_LEN_W-1:0]  burst_len,
  input  logic                  eng_rd_ready,
  input  logic                  eng_wr_ready,
  input  logic                  eng_rd_error,
  input  logic                  eng_wr_error
);

  localparam int unsigned BYTES = AXI_DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned BW    = AXI_LEN_W + 1;
  localparam int unsigned MW0   = (TOTAL_W > 13) ? TOTAL_W : 13;
  localparam int unsigned MW    = (MW0 > BW) ? MW0 : BW;

  localparam logic [AXI_ADDR_W-1:0] OFF_MASK  = AXI_ADDR_W'(BYTES - 1);
  localparam logic [MW-1:0]         MAX_BEATS = MW'(1) << AXI_LEN_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic                    dir_q;
  logic [AXI_ADDR_W-1:0]   cur_addr_q;
  logic [TOTAL_W-1:0]      remaining_q;
  logic [BW-1:0]           beats_q;
  logic                    wait_first_q;
  logic                    ready_q;
  logic                    error_q;
  logic                    run_rd_q;
  logic                    run_wr_q;
  logic [AXI_ADDR_W-1:0]   burst_addr_q;
  logic [AXI_LEN_W-1:0]    burst_len_q;

  logic [12:0]             to_4k_c;
  logic [MW-1:0]           min_c;
  logic [BW-1:0]           beats_c;
  logic                    misaligned_c;
  logic                    eng_ready_c;
  logic                    eng_error_c;
  logic [AXI_ADDR_W-1:0]   cur_addr_d;
  logic [TOTAL_W-1:0]      remaining_d;

  // Burst sizing and post-burst address/remaining arithmetic
  always_comb begin
    to_4k_c      = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFF_W;
    min_c        = (MW'(remaining_q) < MW'(to_4k_c)) ? MW'(remaining_q) : MW'(to_4k_c);
    min_c        = (min_c < MAX_BEATS) ? min_c : MAX_BEATS;
    beats_c      = BW'(min_c);
    misaligned_c = (cur_addr_q & OFF_MASK) != '0;
    eng_ready_c  = dir_q ? eng_wr_ready : eng_rd_ready;
    eng_error_c  = dir_q ? eng_wr_error : eng_rd_error;
    cur_addr_d   = cur_addr_q + (AXI_ADDR_W'(beats_q) << OFF_W);
    remaining_d  = remaining_q - TOTAL_W'(beats_q);
  end

  // Transfer sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      beats_q      <= '0;
      wait_first_q <= 1'b0;
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
      run_rd_q     <= 1'b0;
      run_wr_q     <= 1'b0;
      burst_addr_q <= '0;
      burst_len_q  <= '0;
    end else begin
      run_rd_q <= 1'b0;
      run_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            dir_q       <= direction;
            cur_addr_q  <= addr;
            remaining_q <= length;
            error_q     <= 1'b0;
            ready_q     <= 1'b0;
            state_q     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (misaligned_c) begin
            error_q <= 1'b1;
            state_q <= S_DONE;
          end else if (remaining_q == '0) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          beats_q      <= beats_c;
          burst_addr_q <= cur_addr_q;
          burst_len_q  <= AXI_LEN_W'(beats_c - BW'(1));
          run_rd_q     <= !dir_q;
          run_wr_q     <= dir_q;
          state_q      <= S_ISSUE;
        end
        S_ISSUE: begin
          wait_first_q <= 1'b1;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          // Engine ready still reflects the pre-run idle state in the first cycle
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (eng_ready_c) begin
            if (eng_error_c) begin
              error_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cur_addr_q  <= cur_addr_d;
              remaining_q <= remaining_d;
              state_q     <= (remaining_d == '0) ? S_DONE : S_CALC;
            end
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign error      = error_q;
  assign run_rd     = run_rd_q;
  assign run_wr     = run_wr_q;
  assign burst_addr = burst_addr_q;
  assign burst_len  = burst_len_q;

endmodule

// File: tb/tb_iob2axi_burst_sched.sv
// Scoreboard bench for iob2axi_burst_sched with behavioural read/write engines.
module tb_iob2axi_burst_sched;

  localparam int unsigned AW      = 32;
  localparam int unsigned LW      = 8;
  localparam int unsigned TW      = 16;
  localparam int          ENG_LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          direction = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [TW-1:0] length = '0;
  logic          ready;
  logic          error;
  logic          run_rd;
  logic          run_wr;
  logic [AW-1:0] burst_addr;
  logic [LW-1:0] burst_len;
  logic          eng_rd_ready = 1'b1;
  logic          eng_wr_ready = 1'b1;
  logic          eng_rd_error = 1'b0;
  logic          eng_wr_error = 1'b0;

  iob2axi_burst_sched #(
    .AXI_ADDR_W(32),
    .AXI_DATA_W(32),
    .AXI_LEN_W (8),
    .TOTAL_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .direction   (direction),
    .addr        (addr),
    .length      (length),
    .ready       (ready),
    .error       (error),
    .run_rd      (run_rd),
    .run_wr      (run_wr),
    .burst_addr  (burst_addr),
    .burst_len   (burst_len),
    .eng_rd_ready(eng_rd_ready),
    .eng_wr_ready(eng_wr_ready),
    .eng_rd_error(eng_rd_error),
    .eng_wr_error(eng_wr_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          dir;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          first;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   run_cyc = 0;
  int   last_pulse = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic rd_err_cfg = 1'b0;
  logic wr_err_cfg = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engines: drop ready on run, report completion ENG_LAT cycles later
  always @(negedge clk) begin
    if (rd_cnt > 0) rd_cnt--;
    if (wr_cnt > 0) wr_cnt--;
    eng_rd_ready = (rd_cnt == 0);
    eng_wr_ready = (wr_cnt == 0);
    eng_rd_error = (rd_cnt == 0) ? rd_err_cfg : 1'b0;
    eng_wr_error = (wr_cnt == 0) ? wr_err_cfg : 1'b0;
    if (run_rd) begin
      rd_cnt = ENG_LAT;
      eng_rd_ready = 1'b0;
      eng_rd_error = 1'b0;
    end
    if (run_wr) begin
      wr_cnt = ENG_LAT;
      eng_wr_ready = 1'b0;
      eng_wr_error = 1'b0;
    end
  end

  // Monitor: every burst start is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (run_rd || run_wr)) begin
      check("one_hot_run", 64'(run_rd & run_wr), 64'(0));
      check("burst_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("burst", 64'({run_wr, burst_addr, burst_len}), 64'({e.dir, e.addr, e.len}));
        if (e.first) check("first_latency", 64'(cyc - run_cyc), 64'(3));
        else         check("burst_gap", 64'(cyc - last_pulse), 64'(ENG_LAT + 2));
      end
      last_pulse = cyc;
    end
  end

  task automatic push(input logic d, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic f);
    exp_t e;
    e.dir = d; e.addr = a; e.len = l; e.first = f;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic d, input logic [AW-1:0] a, input logic [TW-1:0] l);
    @(negedge clk);
    direction = d;
    addr      = a;
    length    = l;
    run       = 1'b1;
    run_cyc   = cyc;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_ready(input string name, output int n);
    n = 1;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, 64'(ready), 64'(1));
  endtask

  task automatic finish_xfer(input string name, input logic exp_err);
    int n;
    wait_ready(name, n);
    check({name, "_error"}, 64'(error), 64'(exp_err));
    check({name, "_all_bursts"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_error", 64'(error), 64'(0));
    check("rst_run", 64'({run_rd, run_wr}), 64'(0));
    check("rst_burst_addr", 64'(burst_addr), 64'(0));
    check("rst_burst_len", 64'(burst_len), 64'(0));

    // 4KB split on a write; idle read engine reports an error that must be ignored
    rd_err_cfg = 1'b1;
    push(1'b1, 32'h0FF0, 8'd3, 1'b1);
    push(1'b1, 32'h1000, 8'd15, 1'b0);
    start(1'b1, 32'h0FF0, 16'd20);
    finish_xfer("c1", 1'b0);
    rd_err_cfg = 1'b0;
    repeat (2) @(negedge clk);

    // Max-length splitting on a read, with an ignored run while busy
    push(1'b0, 32'h0000, 8'd255, 1'b1);
    push(1'b0, 32'h0400, 8'd255, 1'b0);
    push(1'b0, 32'h0800, 8'd87, 1'b0);
    start(1'b0, 32'h0, 16'd600);
    repeat (5) @(negedge clk);
    direction = 1'b1; addr = 32'h2000; length = 16'd5; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("c2_busy", 64'(ready), 64'(0));
    finish_xfer("c2", 1'b0);

    // Misaligned start address
    start(1'b0, 32'h0002, 16'd4);
    wait_ready("c3", n);
    check("c3_latency", 64'(n), 64'(3));
    check("c3_error", 64'(error), 64'(1));

    // Zero length clears the previous error
    start(1'b1, 32'h0100, 16'd0);
    wait_ready("c4", n);
    check("c4_latency", 64'(n), 64'(3));
    check("c4_error", 64'(error), 64'(0));
    check("c4_all_bursts", 64'(exp_q.size()), 64'(0));

    // Engine error on the first burst aborts the transfer
    rd_err_cfg = 1'b1;
    push(1'b0, 32'h0000, 8'd255, 1'b1);
    start(1'b0, 32'h0, 16'd600);
    finish_xfer("c5", 1'b1);
    rd_err_cfg = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the first burst's WAIT
    push(1'b0, 32'h0000, 8'd255, 1'b1);
    start(1'b0, 32'h0, 16'd600);
    n = 0;
    while (!run_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("c6_pulse_seen", 64'(run_rd), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("c6_ready", 64'(ready), 64'(1));
    check("c6_run", 64'({run_rd, run_wr}), 64'(0));
    check("c6_burst_addr", 64'(burst_addr), 64'(0));
    check("c6_burst_len", 64'(burst_len), 64'(0));
    repeat (10) @(negedge clk);
    check("c6_all_bursts", 64'(exp_q.size()), 64'(0));
    push(1'b0, 32'h0100, 8'd3, 1'b1);
    start(1'b0, 32'h0100, 16'd4);
    finish_xfer("c6b", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
